// File: rtl/ss_tr_dist_16b_pkg.sv
// Shared definitions for the tr distribution datapath: data width,
// destination count, destination codes and the commit decode helpers.
package ss_tr_dist_16b_pkg;

    localparam int TR_W    = 16;
    localparam int NUM_DST = 5;
    localparam int CNT_W   = 8;

    // Destination codes; 6 and 7 are illegal and must never write.
    typedef enum logic [2:0] {
        DST_A    = 3'd0,
        DST_B    = 3'd1,
        DST_C    = 3'd2,
        DST_D    = 3'd3,
        DST_E    = 3'd4,
        DST_ALL  = 3'd5,
        DST_ILL6 = 3'd6,
        DST_ILL7 = 3'd7
    } dst_e;

    // One-hot write enables for a destination code; broadcast sets all.
    function automatic logic [NUM_DST-1:0] dst_decode(input dst_e code);
        logic [NUM_DST-1:0] en;
        en = '0;
        case (code)
            DST_A:   en = 5'b00001;
            DST_B:   en = 5'b00010;
            DST_C:   en = 5'b00100;
            DST_D:   en = 5'b01000;
            DST_E:   en = 5'b10000;
            DST_ALL: en = 5'b11111;
            default: en = '0;
        endcase
        return en;
    endfunction

    function automatic logic dst_legal(input dst_e code);
        return (code <= DST_ALL);
    endfunction

endpackage

// File: rtl/ss_tr_dist_16b_reg.sv
// One destination register: 16-bit, synchronous active-high reset,
// loaded only when its commit enable is high.
module ss_reg_16b
    import ss_tr_dist_16b_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [TR_W-1:0] d,
    output logic [TR_W-1:0] q
);

    // Hold value unless the commit stage selects this destination.
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (we)
            q <= d;
    end

endmodule

// File: rtl/ss_tr_dist_16b.sv
// Two-stage temp-register distributor: stage 1 captures tr/tr_dst on
// tr_read, stage 2 commits into one or all of five destination registers.
// Tracks per-destination valid flags, flags illegal codes and counts
// legal commits.
module ss_tr_dist_16b
    import ss_tr_dist_16b_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [TR_W-1:0]    tr,
    input  logic               tr_read,
    input  logic [2:0]         tr_dst,
    input  logic [NUM_DST-1:0] ack,
    output logic [TR_W-1:0]    a,
    output logic [TR_W-1:0]    b,
    output logic [TR_W-1:0]    c,
    output logic [TR_W-1:0]    d,
    output logic [TR_W-1:0]    e,
    output logic [NUM_DST-1:0] vld,
    output logic               err,
    output logic               pend,
    output logic [CNT_W-1:0]   wr_cnt
);

    logic                            s1_vld;
    logic [TR_W-1:0]                 s1_data;
    dst_e                            s1_dst;
    logic [NUM_DST-1:0]              wr_en;
    logic                            commit_ok;
    logic                            commit_bad;
    logic [NUM_DST-1:0][TR_W-1:0]    dst_q;

    // Stage 1: capture a request every strobed cycle; valid drops when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s1_dst  <= DST_A;
        end else begin
            s1_vld <= tr_read;
            if (tr_read) begin
                s1_data <= tr;
                s1_dst  <= dst_e'(tr_dst);
            end
        end
    end

    // Stage 2 decode: enables only exist while a captured request is valid.
    assign wr_en      = s1_vld ? dst_decode(s1_dst) : '0;
    assign commit_ok  = s1_vld &&  dst_legal(s1_dst);
    assign commit_bad = s1_vld && !dst_legal(s1_dst);
    assign pend       = s1_vld;

    // Flags and counter: commit beats ack on the same bit; err is a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld    <= '0;
            err    <= 1'b0;
            wr_cnt <= '0;
        end else begin
            vld <= (vld & ~ack) | wr_en;
            err <= commit_bad;
            if (commit_ok)
                wr_cnt <= wr_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_DST; i++) begin : g_dst
        ss_reg_16b u_reg (
            .clk   (clk),
            .reset (reset),
            .we    (wr_en[i]),
            .d     (s1_data),
            .q     (dst_q[i])
        );
    end

    assign a = dst_q[0];
    assign b = dst_q[1];
    assign c = dst_q[2];
    assign d = dst_q[3];
    assign e = dst_q[4];

endmodule

// File: tb/tb_ss_tr_dist_16b.sv
// Directed bench for ss_tr_dist_16b with hand-computed expectations.
module tb_ss_tr_dist_16b;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] tr;
    logic        tr_read;
    logic [2:0]  tr_dst;
    logic [4:0]  ack;
    logic [15:0] a, b, c, d, e;
    logic [4:0]  vld;
    logic        err;
    logic        pend;
    logic [7:0]  wr_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ss_tr_dist_16b dut (
        .clk     (clk),
        .reset   (reset),
        .tr      (tr),
        .tr_read (tr_read),
        .tr_dst  (tr_dst),
        .ack     (ack),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .e       (e),
        .vld     (vld),
        .err     (err),
        .pend    (pend),
        .wr_cnt  (wr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; tr = '0; tr_read = 1'b0; tr_dst = '0; ack = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_a", a, 0);   chk("rst_e", e, 0);
        chk("rst_vld", vld, 0); chk("rst_err", err, 0);
        chk("rst_pend", pend, 0); chk("rst_cnt", wr_cnt, 0);

        // single strobe to a
        tr = 16'h0001; tr_dst = 3'd0; tr_read = 1'b1;
        tick();
        tr_read = 1'b0;
        chk("s1_pend", pend, 1);
        chk("s1_a_early", a, 0);
        tick();
        chk("s1_a", a, 16'h0001); chk("s1_vld", vld, 5'b00001);
        chk("s1_cnt", wr_cnt, 1); chk("s1_b", b, 0); chk("s1_e", e, 0);
        chk("s1_pend_lo", pend, 0);

        // five back-to-back strobes, one per destination
        for (int i = 0; i < 5; i++) begin
            tr = 16'(i); tr_dst = 3'(i); tr_read = 1'b1;
            tick();
        end
        tr_read = 1'b0;
        tick();
        chk("b2b_a", a, 0); chk("b2b_b", b, 1); chk("b2b_c", c, 2);
        chk("b2b_d", d, 3); chk("b2b_e", e, 4);
        chk("b2b_vld", vld, 5'b11111); chk("b2b_cnt", wr_cnt, 6);

        // same destination twice: later value wins
        tr = 16'h1111; tr_dst = 3'd1; tr_read = 1'b1; tick();
        tr = 16'h2222; tick();
        tr_read = 1'b0; tick();
        chk("lw_b", b, 16'h2222); chk("lw_a", a, 0); chk("lw_cnt", wr_cnt, 8);

        // broadcast
        tr = 16'hBEEF; tr_dst = 3'd5; tr_read = 1'b1; tick();
        tr_read = 1'b0; tick();
        chk("bc_a", a, 16'hBEEF); chk("bc_c", c, 16'hBEEF); chk("bc_e", e, 16'hBEEF);
        chk("bc_vld", vld, 5'b11111); chk("bc_cnt", wr_cnt, 9);

        // clear all flags, then illegal code 6: err pulse, nothing written
        ack = 5'b11111; tick(); ack = '0;
        chk("ack_vld", vld, 0); chk("ack_a", a, 16'hBEEF);
        tr = 16'h1234; tr_dst = 3'd6; tr_read = 1'b1; tick();
        tr_read = 1'b0;
        chk("ill_err_early", err, 0);
        tick();
        chk("ill6_err", err, 1); chk("ill6_a", a, 16'hBEEF);
        chk("ill6_vld", vld, 0); chk("ill6_cnt", wr_cnt, 9);
        tick();
        chk("ill6_err_lo", err, 0);
        tr_dst = 3'd7; tr_read = 1'b1; tick();
        tr_read = 1'b0; tick();
        chk("ill7_err", err, 1); chk("ill7_d", d, 16'hBEEF); chk("ill7_cnt", wr_cnt, 9);

        // ack on vld=0 is a no-op
        ack = 5'b00001; tick(); ack = '0;
        chk("noop_vld", vld, 0); chk("noop_a", a, 16'hBEEF);

        // commit to c with ack[2] on the commit edge; then ack alone
        tr = 16'h5555; tr_dst = 3'd2; tr_read = 1'b1; tick();
        tr_read = 1'b0; ack = 5'b00100; tick();
        chk("cw_vld", vld, 5'b00100); chk("cw_c", c, 16'h5555);
        tick(); ack = '0;
        chk("ack_c_vld", vld, 0); chk("ack_c_data", c, 16'h5555);
        chk("cw_cnt", wr_cnt, 10);

        // strobe to d, reset on the next edge discards it
        tr = 16'h7777; tr_dst = 3'd3; tr_read = 1'b1; tick();
        tr_read = 1'b0; reset = 1'b1; tick();
        reset = 1'b0;
        chk("rf_d", d, 0); chk("rf_vld", vld, 0); chk("rf_pend", pend, 0);
        chk("rf_cnt", wr_cnt, 0); chk("rf_a", a, 0);
        tick(); tick();
        chk("rf_d_late", d, 0); chk("rf_vld_late", vld, 0); chk("rf_cnt_late", wr_cnt, 0);

        // reset wins over tr_read and ack in the same cycle
        reset = 1'b1; tr_read = 1'b1; ack = 5'b11111; tick();
        reset = 1'b0; tr_read = 1'b0; ack = '0;
        chk("rp_pend", pend, 0);
        tick();
        chk("rp_vld", vld, 0); chk("rp_cnt", wr_cnt, 0);

        // 256 legal commits wrap the counter
        tr_dst = 3'd4; tr_read = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tr = 16'(i);
            tick();
            if (i == 255) chk("wrap_pre", wr_cnt, 255);
        end
        tr_read = 1'b0; tick();
        chk("wrap_cnt", wr_cnt, 0); chk("wrap_e", e, 16'h00FF);
        chk("wrap_vld", vld, 5'b10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ss_tr_dist_16b.md
SS_TR_DIST_16B -- requirements
Module: ss_tr_dist_16b

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK  input  1  rising-edge clock.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-003 tr  input  16  temp-register value to distribute.
REQ-004 tr_read  input  1  distribute strobe; one request per cycle asserted.
REQ-005 tr_dst  input  3  destination code: 0..4 = a..e, 5 = broadcast to all, 6..7 = illegal.
REQ-006 ack  input  5  per-destination consume strobes; bit0 = a … bit4 = e.
REQ-007 a, b, c, d, e  output  16 each  destination registers.
REQ-008 vld  output  5  per-destination data-valid flags; bit order as ack.
REQ-009 err  output  1  one-cycle pulse for an illegal destination code.
REQ-010 pend  output  1  high while a captured request awaits commit (stage-1 valid).
REQ-011 wr_cnt  output  8  count of committed legal requests; wraps 255 -> 0.

Function
REQ-012 Stage 1 (capture) SHALL register tr, tr_dst and a valid bit on every edge where tr_read=1; stage-1 valid clears when tr_read=0.
REQ-013 Stage 2 (commit) SHALL load the selected destination register(s) from captured data on the following edge; latency tr_read -> output = 2 edges.
REQ-014 Back-to-back strobes SHALL pipeline at full rate, with no stall and no lost request.
REQ-015 Consecutive requests to the same destination SHALL leave the later value in the register (last wins).
REQ-016 Commit of code 0..4 SHALL load only that register and set only that vld bit; other registers and flags hold.
REQ-017 Commit of code 5 SHALL load all five registers with the same value and set all vld bits.
REQ-018 Commit of code 6/7 SHALL write nothing, leave vld unchanged, pulse err for exactly the commit cycle, and not increment wr_cnt.
REQ-019 An ack bit SHALL clear its vld bit on the next edge; ack SHALL not alter register data.
REQ-020 Commit and ack on the same destination in the same cycle SHALL leave vld=1 (commit wins).
REQ-021 An ack on a destination with vld=0 SHALL be a no-op.
REQ-022 wr_cnt SHALL increment by 1 per legal commit (broadcast counts once) and wrap modulo 256.
REQ-023 pend SHALL equal the stage-1 valid bit, registered.

Reset
REQ-024 reset=1 SHALL clear a..e to 16'h0000, vld to 5'b0, err to 0, pend to 0, wr_cnt to 0, and both pipeline stages' valid bits on the same edge.
REQ-025 A request in flight when reset asserts SHALL be discarded, and nothing SHALL commit after reset deasserts.
REQ-026 reset SHALL take priority over tr_read and ack in the same cycle.

Structure
REQ-027 Destination codes (DST_A..DST_E, DST_ALL, illegal range) and the 16-bit width SHALL live in the shared definitions header used by the tr datapath blocks.
REQ-028 Each destination SHALL be an instance of one sub-module, ss_reg_16b (16-bit register, synchronous active-high reset, write enable); the five instances SHALL be generated from the decoded commit enables.
REQ-029 Decode, the vld/err logic, wr_cnt and the pipeline registers SHALL live in ss_tr_dist_16b.

Verification
REQ-030 Reset, then tr=16'h0001 with dst=0 on a single strobe -> a=1 and vld=5'b00001 two edges later; wr_cnt=1; b..e=0.
REQ-031 Five consecutive strobes with tr=0..4 and dst=0..4 -> after 6 edges a..e=0,1,2,3,4, vld=5'b11111, wr_cnt=5.
REQ-032 dst=5, tr=16'hBEEF -> all outputs = BEEF, vld=5'b11111, wr_cnt +1; then dst=6 -> err high one cycle, registers unchanged, wr_cnt unchanged.
REQ-033 Commit to c plus ack[2] in the same cycle -> vld[2] stays 1; ack[2] on the next cycle alone -> vld[2]=0 while c is retained.
REQ-034 Strobe to d, then reset asserted on the next edge -> d=0, vld=0, pend=0, and no later commit; 256 legal commits -> wr_cnt wraps to 0.
